// File: rtl/ara_eoc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ara_eoc_pkg                                                                |
// | Shared types and constants for the Ara end-of-computation monitor.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package ara_eoc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Widest code carried per channel; exit words up to 64 bits are supported.
    localparam int unsigned MaxCodeWidth = 63;

    typedef struct packed {
        logic                    reported;
        logic [MaxCodeWidth-1:0] code;
    } chan_status_t;

    localparam logic [MaxCodeWidth-1:0] ExitCodeTimeout = '1;

    function automatic logic code_failed(input chan_status_t s);
        return s.reported && (s.code != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ara_eoc_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ara_eoc_channel                                                            |
// | Sticky per-channel exit-word latch: first report wins, later ones ignored. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ara_eoc_channel
    import ara_eoc_pkg::*;
#(
    parameter int unsigned ExitWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en,
    input  logic [ExitWidth-1:0] exit_word,
    output logic                 reported,
    output chan_status_t         status_next
);

    chan_status_t status;

    // status_next is exported so the monitor can react in the same cycle the
    // report arrives, rather than one cycle after the latch updates.
    always_comb begin
        status_next = status;
        if (en && !status.reported && exit_word[0]) begin
            status_next.reported = 1'b1;
            status_next.code     = MaxCodeWidth'(exit_word[ExitWidth-1:1]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status <= '0;
        end else begin
            status <= status_next;
        end
    end

    assign reported = status.reported;

endmodule
`default_nettype wire

// File: rtl/ara_eoc_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ara_eoc_monitor                                                            |
// | Multi-channel end-of-computation monitor: run counter, fail-fast, drain,   |
// | finish pulse. Optional watchdog enabled by ARA_EOC_WATCHDOG_EN.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ara_eoc_monitor
    import ara_eoc_pkg::*;
#(
    parameter int unsigned NrChannels    = 1,
    parameter int unsigned ExitWidth     = 64,
    parameter int unsigned CntWidth      = 64,
    parameter int unsigned DrainCycles   = 4,
    parameter int unsigned TimeoutCycles = 1000000,
    localparam int unsigned ChanWidth    = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [NrChannels-1:0][ExitWidth-1:0] exit_i,
    output logic [NrChannels-1:0]                reported_o,
    output logic                                 done_o,
    output logic                                 finish_o,
    output logic                                 fail_o,
    output logic                                 timeout_o,
    output logic [ChanWidth-1:0]                 fail_chan_o,
    output logic [ExitWidth-2:0]                 exit_code_o,
    output logic [CntWidth-1:0]                  cycles_o,
    output state_e                               state_o
);

    localparam int unsigned          DrainWidth = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    localparam logic [DrainWidth-1:0] DrainLoad = DrainWidth'(DrainCycles - 1);

    logic         in_run;
    chan_status_t chan_next [NrChannels];

    assign in_run = (state_o == RUN);

    for (genvar i = 0; i < NrChannels; i++) begin : g_chan
        ara_eoc_channel #(
            .ExitWidth (ExitWidth)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en          (in_run),
            .exit_word   (exit_i[i]),
            .reported    (reported_o[i]),
            .status_next (chan_next[i])
        );
    end

    logic                 all_reported;
    logic                 any_fail;
    logic [ChanWidth-1:0] first_chan;
    logic [ExitWidth-2:0] first_code;
    logic                 exit_cond;

    // Scan high-to-low so the lowest failing index is the last one written.
    always_comb begin
        all_reported = 1'b1;
        any_fail     = 1'b0;
        first_chan   = '0;
        first_code   = '0;
        for (int i = int'(NrChannels) - 1; i >= 0; i--) begin
            all_reported = all_reported & chan_next[i].reported;
            if (code_failed(chan_next[i])) begin
                any_fail   = 1'b1;
                first_chan = ChanWidth'(i);
                first_code = chan_next[i].code[ExitWidth-2:0];
            end
        end
    end

    assign exit_cond = all_reported | any_fail;

`ifdef ARA_EOC_WATCHDOG_EN
    logic timeout_hit;
    assign timeout_hit = !exit_cond && (64'(cycles_o) == 64'(TimeoutCycles - 1));
`else
    assign timeout_o = 1'b0;
`endif

    logic [DrainWidth-1:0] drain_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o     <= IDLE;
            drain_cnt   <= '0;
            cycles_o    <= '0;
            done_o      <= 1'b0;
            finish_o    <= 1'b0;
            fail_o      <= 1'b0;
            fail_chan_o <= '0;
            exit_code_o <= '0;
`ifdef ARA_EOC_WATCHDOG_EN
            timeout_o   <= 1'b0;
`endif
        end else begin
            finish_o <= 1'b0;
            case (state_o)
                IDLE: begin
                    if (start_i) begin
                        state_o <= RUN;
                    end
                end
                RUN: begin
                    if (exit_cond) begin
                        state_o     <= DRAIN;
                        drain_cnt   <= DrainLoad;
                        fail_o      <= any_fail;
                        fail_chan_o <= first_chan;
                        exit_code_o <= first_code;
`ifdef ARA_EOC_WATCHDOG_EN
                    end else if (timeout_hit) begin
                        state_o     <= DRAIN;
                        drain_cnt   <= DrainLoad;
                        fail_o      <= 1'b1;
                        timeout_o   <= 1'b1;
                        fail_chan_o <= '0;
                        exit_code_o <= ExitCodeTimeout[ExitWidth-2:0];
`endif
                    end else if (cycles_o != '1) begin
                        // Counter holds its last RUN value once we leave RUN.
                        cycles_o <= cycles_o + CntWidth'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state_o  <= DONE;
                        done_o   <= 1'b1;
                        finish_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DrainWidth'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
